// File: rtl/oq_sram_ctrl_if.sv
// Request/response and SRAM pad bundle of oq_sram_ctrl.
// slave = the controller; master = requesters plus the SRAM pads.
interface oq_sram_ctrl_if #(
    parameter int DATA_WIDTH      = 64,
    parameter int SRAM_ADDR_WIDTH = 19
);
    localparam int CTRL_WIDTH = DATA_WIDTH / 8;
    localparam int WORD_WIDTH = DATA_WIDTH + CTRL_WIDTH;

    logic                       wr_0_req;
    logic [SRAM_ADDR_WIDTH-1:0] wr_0_addr;
    logic [WORD_WIDTH-1:0]      wr_0_data;
    logic                       wr_0_ack;

    logic                       rd_0_req;
    logic [SRAM_ADDR_WIDTH-1:0] rd_0_addr;
    logic                       rd_0_ack;
    logic [WORD_WIDTH-1:0]      rd_0_data;
    logic                       rd_0_vld;

    logic [SRAM_ADDR_WIDTH-1:0] sram_addr;
    logic                       sram_we_n;
    logic [7:0]                 sram_bw_n;
    logic [WORD_WIDTH-1:0]      sram_wr_data;
    logic                       sram_tri_en;
    logic [WORD_WIDTH-1:0]      sram_rd_data;

    logic [31:0]                wr_cnt;
    logic [31:0]                rd_cnt;

    modport slave (
        input  wr_0_req, wr_0_addr, wr_0_data,
        input  rd_0_req, rd_0_addr,
        input  sram_rd_data,
        output wr_0_ack, rd_0_ack, rd_0_data, rd_0_vld,
        output sram_addr, sram_we_n, sram_bw_n, sram_wr_data, sram_tri_en,
        output wr_cnt, rd_cnt
    );

    modport master (
        output wr_0_req, wr_0_addr, wr_0_data,
        output rd_0_req, rd_0_addr,
        output sram_rd_data,
        input  wr_0_ack, rd_0_ack, rd_0_data, rd_0_vld,
        input  sram_addr, sram_we_n, sram_bw_n, sram_wr_data, sram_tri_en,
        input  wr_cnt, rd_cnt
    );
endinterface

// File: rtl/oq_sram_ctrl.sv
// Round-robin write/read arbiter driving a 2-cycle pipelined single-port SRAM.
// Optional access counters enabled by defining OQ_SRAM_ACCESS_CNT_EN.
module oq_sram_ctrl #(
    parameter int DATA_WIDTH      = 64,
    parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
    parameter int SRAM_ADDR_WIDTH = 19
) (
    input logic           clk,
    input logic           reset,
    oq_sram_ctrl_if.slave bus
);
    localparam int WORD_WIDTH = DATA_WIDTH + CTRL_WIDTH;

    logic                       r_wrAck;
    logic                       r_rdAck;
    logic                       r_lastWr;
    logic [SRAM_ADDR_WIDTH-1:0] r_sramAddr;
    logic                       r_weN;
    logic [7:0]                 r_bwN;
    logic [WORD_WIDTH-1:0]      r_wrData1;
    logic [WORD_WIDTH-1:0]      r_wrData2;
    logic                       r_wrVld2;
    logic [WORD_WIDTH-1:0]      r_sramWrData;
    logic                       r_triEn;
    logic                       r_rdVld2;
    logic                       r_rdVld3;
    logic                       r_rdVld;
    logic [WORD_WIDTH-1:0]      r_rdData;

    logic w_wrElig;
    logic w_rdElig;
    logic w_grantWr;
    logic w_grantRd;

    // A port whose ack is high this cycle is presenting a stale request.
    assign w_wrElig  = bus.wr_0_req && !r_wrAck;
    assign w_rdElig  = bus.rd_0_req && !r_rdAck;
    assign w_grantWr = w_wrElig && (!w_rdElig || !r_lastWr);
    assign w_grantRd = w_rdElig && (!w_wrElig || r_lastWr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrAck      <= 1'b0;
            r_rdAck      <= 1'b0;
            r_lastWr     <= 1'b1;
            r_sramAddr   <= '0;
            r_weN        <= 1'b1;
            r_bwN        <= 8'hFF;
            r_wrData1    <= '0;
            r_wrData2    <= '0;
            r_wrVld2     <= 1'b0;
            r_sramWrData <= '0;
            r_triEn      <= 1'b0;
            r_rdVld2     <= 1'b0;
            r_rdVld3     <= 1'b0;
            r_rdVld      <= 1'b0;
            r_rdData     <= '0;
        end else begin
            r_wrAck <= w_grantWr;
            r_rdAck <= w_grantRd;
            if (w_grantWr) begin
                r_sramAddr <= bus.wr_0_addr;
                r_weN      <= 1'b0;
                r_bwN      <= 8'h00;
                r_wrData1  <= bus.wr_0_data;
                r_lastWr   <= 1'b1;
            end else if (w_grantRd) begin
                r_sramAddr <= bus.rd_0_addr;
                r_weN      <= 1'b1;
                r_bwN      <= 8'hFF;
                r_lastWr   <= 1'b0;
            end else begin
                r_weN <= 1'b1;
                r_bwN <= 8'hFF;
            end

            // Both data slots land two cycles after the address cycle.
            r_wrVld2  <= r_wrAck;
            r_wrData2 <= r_wrData1;
            r_triEn   <= r_wrVld2;
            if (r_wrVld2) begin
                r_sramWrData <= r_wrData2;
            end

            r_rdVld2 <= r_rdAck;
            r_rdVld3 <= r_rdVld2;
            r_rdVld  <= r_rdVld3;
            if (r_rdVld3) begin
                r_rdData <= bus.sram_rd_data;
            end
        end
    end

    assign bus.wr_0_ack     = r_wrAck;
    assign bus.rd_0_ack     = r_rdAck;
    assign bus.rd_0_data    = r_rdData;
    assign bus.rd_0_vld     = r_rdVld;
    assign bus.sram_addr    = r_sramAddr;
    assign bus.sram_we_n    = r_weN;
    assign bus.sram_bw_n    = r_bwN;
    assign bus.sram_wr_data = r_sramWrData;
    assign bus.sram_tri_en  = r_triEn;

`ifdef OQ_SRAM_ACCESS_CNT_EN
    logic [31:0] r_wrCnt;
    logic [31:0] r_rdCnt;

    // Saturating counters, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrCnt <= '0;
            r_rdCnt <= '0;
        end else begin
            if (r_wrAck && (r_wrCnt != 32'hFFFF_FFFF)) begin
                r_wrCnt <= r_wrCnt + 32'd1;
            end
            if (r_rdAck && (r_rdCnt != 32'hFFFF_FFFF)) begin
                r_rdCnt <= r_rdCnt + 32'd1;
            end
        end
    end

    assign bus.wr_cnt = r_wrCnt;
    assign bus.rd_cnt = r_rdCnt;
`else
    assign bus.wr_cnt = '0;
    assign bus.rd_cnt = '0;
`endif

endmodule

// File: doc/oq_sram_ctrl.md
# oq_sram_ctrl

Responder side of the output-queue SRAM request interface. Accepts write requests (`wr_0_*`) from the packet store path and read requests (`rd_0_*`) from the packet remove path. Arbitrates between them and drives a single-port pipelined (ZBT-style, 2-cycle) external SRAM. Returns read data with fixed latency. Sits between `output_queues` and the SRAM pads.

## Interface
Parameters:
- `DATA_WIDTH`, 64, datapath data bits
- `CTRL_WIDTH`, `DATA_WIDTH/8`, datapath ctrl bits; SRAM word is `DATA_WIDTH+CTRL_WIDTH` (72)
- `SRAM_ADDR_WIDTH`, 19, SRAM word address bits

Ports (clock and reset first; single clock; reset asynchronous, active-low):
- `clk`  in  1  clock
- `reset`  in  1  asynchronous active-low reset
- `wr_0_req`  in  1  write request, held until ack
- `wr_0_addr`  in  SRAM_ADDR_WIDTH  write address
- `wr_0_data`  in  72  write word
- `wr_0_ack`  out  1  one-cycle pulse: write issued
- `rd_0_req`  in  1  read request, held until ack
- `rd_0_addr`  in  SRAM_ADDR_WIDTH  read address
- `rd_0_ack`  out  1  one-cycle pulse: read issued
- `rd_0_data`  out  72  read word, valid with `rd_0_vld`
- `rd_0_vld`  out  1  one-cycle pulse per completed read
- `sram_addr`  out  SRAM_ADDR_WIDTH  registered SRAM address
- `sram_we_n`  out  1  active-low write enable
- `sram_bw_n`  out  8  active-low byte writes (all asserted on write)
- `sram_wr_data`  out  72  write data to pads
- `sram_tri_en`  out  1  1 = drive `sram_wr_data` onto bus
- `sram_rd_data`  in  72  data from pads
- `wr_cnt`, `rd_cnt`  out  32  access counters (see Configuration)

## Operation
- Cycle T: arbiter samples eligible requests. A port is eligible when its `req`=1 and its `ack` is not high in T. An asserted ack marks `req`/`addr` as stale for that cycle.
- Both eligible: round-robin. Grant the port not granted last. After reset, `last_grant`=write, so read wins the first contention.
- One eligible: grant it; `last_grant` updated.
- Grant registered at T+1: matching `ack`=1, `sram_addr`=granted addr, `sram_we_n`=0 (write) / 1 (read), `sram_bw_n`=0x00 (write) / 0xFF.
- No grant at T+1: `sram_we_n`=1, `sram_bw_n`=0xFF, `sram_addr` holds.
- Write data pipe: `wr_0_data` captured at grant, driven on `sram_wr_data` with `sram_tri_en`=1 in T+3 only.
- Read pipe: SRAM presents data in T+3; block registers it; `rd_0_data`/`rd_0_vld`=1 in T+4.
- Read and write data slots are both address+2, so alternating rd/wr never collides on the bus and needs no idle turnaround cycle.
- Per-port throughput is at most 1 access / 2 cycles. Alternating ports reach 1 access/cycle.
- Read-after-write to the same address issued in consecutive cycles returns the new data (SRAM pipeline order). No forwarding logic.

## Timing
- Reset values: `wr_0_ack`=`rd_0_ack`=`rd_0_vld`=0, `rd_0_data`=0, `sram_addr`=0, `sram_we_n`=1, `sram_bw_n`=0xFF, `sram_wr_data`=0, `sram_tri_en`=0, counters 0. All pipeline valid bits clear.
- Latency: request to ack 1 cycle (uncontended). Ack to `rd_0_vld` 3 cycles. Ack to write data on bus 2 cycles.
- Reset asserted mid-operation: all in-flight accesses discarded. No `rd_0_vld` is produced for them, and `sram_tri_en` drops immediately (async).
- `req` deasserted before ack: request is withdrawn, no access, no ack.
- Requester may hold `req` high across ack to issue back-to-back. The next request is the one sampled the cycle after ack.

## Configuration
- `OQ_SRAM_ACCESS_CNT_EN` defined: `wr_cnt` / `rd_cnt` increment on each `wr_0_ack` / `rd_0_ack`. They saturate at 0xFFFFFFFF and clear only on reset.
- Macro undefined: both outputs tied to 0; no counter logic.

## Test plan
- Single write addr 0x00010, data 0x55..AA, then read 0x00010. Required: `wr_0_ack` at T+1, bus driven T+3, `sram_we_n`=0 at T+1; read returns 0x55..AA with `rd_0_vld` exactly 3 cycles after `rd_0_ack`.
- Both `req` held high continuously after reset. Required: acks alternate rd, wr, rd, wr…; one SRAM access every cycle; no `sram_tri_en` in a cycle where read data is due.
- Read-only `req` held high for 8 sequential addresses. Required: 8 `rd_0_ack` pulses, one every 2 cycles; 8 `rd_0_vld` pulses in address order.
- Reset pulled low 1 cycle after a read ack. Required: no `rd_0_vld`, all outputs at reset values, next request after reset serviced normally.
- Write then read the same address in consecutive grant cycles. Required: read returns the new data.
- With `OQ_SRAM_ACCESS_CNT_EN`: 5 writes and 3 reads give `wr_cnt`=5, `rd_cnt`=3. Counter preloaded to 0xFFFFFFFF in simulation stays at 0xFFFFFFFF on further acks. Without the macro, both counters read 0.
